// File: rtl/serial_deser8.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a bit stream in
// either direction and hands them off through a valid/ready holding register.
module serial_deser8 #(
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     shift_right,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;

  logic [WIDTH-1:0] sreg, sreg_shift;
  logic             dir, dir_eff, word_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n   = state;
    word_done = 1'b0;
    busy      = (state == SHIFT);
    case (state)
      IDLE:  if (bit_valid) state_n = SHIFT;
      SHIFT: if (bit_valid && bit_count == LAST) begin
        state_n   = IDLE;
        word_done = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // The first bit of a word uses the live direction input; later bits use the latched copy.
  assign dir_eff    = (state == IDLE) ? shift_right : dir;
  assign sreg_shift = dir_eff ? {bit_in, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], bit_in};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg       <= '0;
      dir        <= 1'b0;
      bit_count  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      sreg       <= '0;
      dir        <= 1'b0;
      bit_count  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (bit_valid) begin
        if (state == IDLE) dir <= shift_right;
        if (word_done) begin
          sreg      <= '0;
          bit_count <= '0;
        end else begin
          sreg      <= sreg_shift;
          bit_count <= bit_count + 1'b1;
        end
      end
      // A completing word keeps data_valid high even if the old word is consumed now.
      if (word_done) begin
        data_out   <= sreg_shift;
        data_valid <= 1'b1;
        if (data_valid && !data_ready) overrun <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_deser8.sv
// Randomized and directed bench for serial_deser8 against a queue-based word model.
module tb_serial_deser8;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         bit_in = 1'b0, bit_valid = 1'b0, shift_right = 1'b0, data_ready = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid, overrun, busy;
  logic [2:0]   bit_count;

  int checks = 0;
  int errors = 0;

  serial_deser8 #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .clear(clear), .bit_in(bit_in),
    .bit_valid(bit_valid), .shift_right(shift_right), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .overrun(overrun),
    .bit_count(bit_count), .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference model: bits of the word in progress, in arrival order.
  int           m_bits[$];
  logic         m_dir;
  logic [W-1:0] m_out;
  logic         m_valid, m_ovr;

  task automatic m_reset();
    m_bits.delete();
    m_dir = 1'b0; m_out = '0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  function automatic logic [W-1:0] m_word();
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++)
      if (m_dir) w[i] = m_bits[i][0];
      else       w = {w[W-2:0], m_bits[i][0]};
    return w;
  endfunction

  function automatic logic [13:0] m_vec();
    return {m_out, m_valid, m_ovr, 3'(m_bits.size()), (m_bits.size() != 0)};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {data_out, data_valid, overrun, bit_count, busy};
  endfunction

  // Apply inputs for one cycle, advance the model, and land #1 after the edge.
  task automatic step(input logic bv, input logic b, input logic sr, input logic rdy, input logic clr);
    logic consume;
    bit_valid = bv; bit_in = b; shift_right = sr; data_ready = rdy; clear = clr;
    if (clr) m_reset();
    else begin
      consume = m_valid && rdy;
      if (bv) begin
        if (m_bits.size() == 0) m_dir = sr;
        m_bits.push_back(int'(b));
      end
      if (m_bits.size() == W) begin
        if (m_valid && !rdy) m_ovr = 1'b1;
        m_out = m_word(); m_valid = 1'b1;
        m_bits.delete();
      end else if (consume) m_valid = 1'b0;
    end
    @(posedge clock); #1;
    clear = 1'b0; bit_valid = 1'b0;
  endtask

  // Sends seq[W-1] first, seq[0] last.
  task automatic send_seq(input logic [W-1:0] seq, input logic sr, input logic rdy);
    for (int i = W-1; i >= 0; i--) step(1'b1, seq[i], sr, rdy, 1'b0);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (dut_vec() !== 14'd0) begin
      errors++; $display("FAIL reset_state got=%h want=%h", dut_vec(), 14'd0);
    end
    m_reset();
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_msb_first();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_seq(8'h12, 1'b0, 1'b1);
    checks++;
    if (data_out !== 8'h12 || data_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL msb_first got=%h/%b/%b want=12/1/0", data_out, data_valid, overrun);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (data_valid !== 1'b0 || data_out !== 8'h12) begin
      errors++; $display("FAIL msb_valid_drop got=%b/%h want=0/12", data_valid, data_out);
    end
  endtask

  task automatic test_lsb_first();
    send_seq(8'h12, 1'b1, 1'b1);
    checks++;
    if (data_out !== 8'h48 || data_valid !== 1'b1) begin
      errors++; $display("FAIL lsb_first got=%h/%b want=48/1", data_out, data_valid);
    end
    // Direction flips after the third bit; word must still assemble right-shifted.
    for (int i = W-1; i >= 0; i--) step(1'b1, 8'h12 >> i, (i > 4), 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h48) begin
      errors++; $display("FAIL dir_midword got=%h want=48", data_out);
    end
    send_seq(8'h12, 1'b0, 1'b1);
    checks++;
    if (data_out !== 8'h12) begin
      errors++; $display("FAIL dir_next_word got=%h want=12", data_out);
    end
  endtask

  task automatic test_overrun_clear();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_seq(8'hA5, 1'b0, 1'b0);
    send_seq(8'h3C, 1'b0, 1'b0);
    checks++;
    if (data_out !== 8'h3C || data_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++; $display("FAIL overrun got=%h/%b/%b want=3c/1/1", data_out, data_valid, overrun);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (dut_vec() !== 14'd0) begin
      errors++; $display("FAIL clear got=%h want=%h", dut_vec(), 14'd0);
    end
  endtask

  task automatic test_simul_handshake();
    send_seq(8'h12, 1'b0, 1'b0);
    for (int i = 0; i < W-1; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (data_out !== 8'h12 || data_valid !== 1'b1 || bit_count !== 3'd7) begin
      errors++; $display("FAIL simul_pre got=%h/%b/%0d want=12/1/7", data_out, data_valid, bit_count);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'hFF || data_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL simul_hs got=%h/%b/%b want=ff/1/0", data_out, data_valid, overrun);
    end
  endtask

  task automatic test_gapped();
    logic [W-1:0] seq = 8'hC3;
    int k = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 16; c++) begin
      if (c % 2 == 0) begin step(1'b1, seq[W-1-k], 1'b0, 1'b1, 1'b0); k++; end
      else step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (bit_count !== 3'(k % W)) begin
        errors++; $display("FAIL gapped_count cyc=%0d got=%0d want=%0d", c, bit_count, k % W);
      end
      if (k == W && c == 14) begin
        checks++;
        if (data_out !== 8'hC3 || data_valid !== 1'b1) begin
          errors++; $display("FAIL gapped_word got=%h/%b want=c3/1", data_out, data_valid);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    m_reset();
    checks++;
    if (dut_vec() !== 14'd0) begin
      errors++; $display("FAIL async_reset got=%h want=%h", dut_vec(), 14'd0);
    end
    reset = 1'b0;
    send_seq(8'h5A, 1'b0, 1'b0);
    checks++;
    if (data_out !== 8'h5A || data_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL post_reset got=%h/%b/%b want=5a/1/0", data_out, data_valid, overrun);
    end
  endtask

  task automatic test_random();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
      checks++;
      if (dut_vec() !== m_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h want=%h", c, dut_vec(), m_vec());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun_clear();
    test_simul_handshake();
    test_gapped();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
